// File: rtl/dense_layer_seq_pkg.sv
// dense_pkg: shared FSM encoding, coefficient address map and saturation helper for layer blocks.
// Latency: none (types and pure functions only).
// Backpressure: none.
package dense_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_WB   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Working width of the saturation helper; callers sign-extend into it.
  localparam int SAT_W = 64;

  // Ceiling log2, never below 1 so that single-entry counters still get a bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // Weights are stored row-major per output neuron.
  function automatic int weight_index(input int o, input int i, input int n_in);
    return o * n_in + i;
  endfunction

  // Biases follow directly after the last weight.
  function automatic int bias_base(input int n_in, input int n_out);
    return n_in * n_out;
  endfunction

  // Clamp a signed value to the signed range of a w-bit word.
  function automatic logic signed [SAT_W-1:0] sat_to_w(input logic signed [SAT_W-1:0] v,
                                                      input int w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/dense_layer_seq_if.sv
// dense_layer_seq_if: block-level handshake, input vector, coefficient port and result bus.
// Latency: none (wiring only).
// Backpressure: none; ap_ready/ap_done pulses carry all flow control.
interface dense_layer_seq_if #(
  parameter int N_IN   = 2,
  parameter int N_OUT  = 1,
  parameter int DATA_W = 16
) ();
  import dense_pkg::*;

  localparam int ADDR_W = clog2(N_IN * N_OUT + N_OUT);

  logic                      ap_start;
  logic                      ap_done;
  logic                      ap_idle;
  logic                      ap_ready;
  logic                      in_vld;
  logic [N_IN*DATA_W-1:0]    in_data;
  logic                      cfg_we;
  logic [ADDR_W-1:0]         cfg_addr;
  logic [DATA_W-1:0]         cfg_wdata;
  logic [N_OUT*DATA_W-1:0]   out_data;
  logic                      out_vld;

  modport master (
    output ap_start, in_vld, in_data, cfg_we, cfg_addr, cfg_wdata,
    input  ap_done, ap_idle, ap_ready, out_data, out_vld
  );

  modport slave (
    input  ap_start, in_vld, in_data, cfg_we, cfg_addr, cfg_wdata,
    output ap_done, ap_idle, ap_ready, out_data, out_vld
  );

endinterface

// File: rtl/dense_layer_seq_fx_requant.sv
// fx_requant: floor-shift accumulator, add bias, optional clamp (else wrap), optional ReLU.
// Latency: combinational.
// Backpressure: none.
module fx_requant
  import dense_pkg::*;
#(
  parameter int ACC_W      = 40,
  parameter int DATA_W     = 16,
  parameter int FRAC_SHIFT = 10,
  parameter int SATURATE   = 1,
  parameter int RELU       = 0
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  input  logic signed [DATA_W-1:0] bias_i,
  output logic signed [DATA_W-1:0] y_o
);

  // One extra bit so the bias add can never overflow before the clamp.
  // ACC_W must stay below SAT_W so the sum fits the helper's working width.
  logic signed [ACC_W-1:0]  shifted;
  logic signed [ACC_W:0]    sum;
  logic signed [SAT_W-1:0]  sum64;
  logic signed [SAT_W-1:0]  sat64;
  logic signed [DATA_W-1:0] r;
  logic                     unused_hi;

  assign shifted   = acc_i >>> FRAC_SHIFT;
  assign sum       = {shifted[ACC_W-1], shifted}
                   + {{(ACC_W + 1 - DATA_W){bias_i[DATA_W-1]}}, bias_i};
  assign unused_hi = ^sat64[SAT_W-1:DATA_W];

  // Range handling first, then ReLU on the DATA_W result.
  always_comb begin
    sum64 = {{(SAT_W - 1 - ACC_W){sum[ACC_W]}}, sum};
    if (SATURATE != 0) sat64 = sat_to_w(sum64, DATA_W);
    else               sat64 = sum64;
    r = sat64[DATA_W-1:0];
    if ((RELU != 0) && r[DATA_W-1]) r = '0;
    y_o = r;
  end

endmodule

// File: rtl/dense_layer_seq.sv
// dense_layer_seq: time-multiplexed fully-connected layer, one multiply-accumulate per cycle.
// Latency: ap_done N_OUT*(N_IN+1)+1 cycles after the accepting edge.
// Backpressure: vector accepted only in IDLE with ap_start && in_vld; results are held, never stalled.
module dense_layer_seq
  import dense_pkg::*;
#(
  parameter int N_IN       = 2,
  parameter int N_OUT      = 1,
  parameter int DATA_W     = 16,
  parameter int FRAC_SHIFT = 10,
  parameter int ACC_W      = 40,
  parameter int SATURATE   = 1,
  parameter int RELU       = 0
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  dense_layer_seq_if.slave bus
);

  localparam int N_W    = N_IN * N_OUT;
  localparam int N_C    = N_W + N_OUT;
  localparam int B_BASE = bias_base(N_IN, N_OUT);
  localparam int IW     = clog2(N_IN);
  localparam int OW     = clog2(N_OUT);
  localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
  localparam logic [OW-1:0] O_LAST = OW'(N_OUT - 1);

  state_e                    state_q, state_d;
  logic                      accept;
  logic [N_IN*DATA_W-1:0]    x_q;
  logic signed [DATA_W-1:0]  coef_q [N_C];
  logic signed [ACC_W-1:0]   acc_q;
  logic [IW-1:0]             i_q;
  logic [OW-1:0]             o_q;
  logic [N_OUT*DATA_W-1:0]   out_q;
  logic signed [DATA_W-1:0]  x_sel, w_sel, b_sel, y_wb;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]   prod_ext;

  assign accept       = (state_q == ST_IDLE) && bus.ap_start && bus.in_vld;
  assign bus.out_data = out_q;

  // Pick the current activation, weight and bias from the o/i counters.
  always_comb begin
    x_sel = '0;
    w_sel = '0;
    b_sel = '0;
    for (int k = 0; k < N_IN; k++)
      if (int'(i_q) == k) x_sel = x_q[k*DATA_W +: DATA_W];
    for (int k = 0; k < N_W; k++)
      if (weight_index(int'(o_q), int'(i_q), N_IN) == k) w_sel = coef_q[k];
    for (int k = 0; k < N_OUT; k++)
      if (int'(o_q) == k) b_sel = coef_q[B_BASE + k];
  end

  // Full-precision product, sign-extended to the accumulator.
  assign prod     = x_sel * w_sel;
  assign prod_ext = {{(ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod};

  fx_requant #(
    .ACC_W      (ACC_W),
    .DATA_W     (DATA_W),
    .FRAC_SHIFT (FRAC_SHIFT),
    .SATURATE   (SATURATE),
    .RELU       (RELU)
  ) u_requant (
    .acc_i  (acc_q),
    .bias_i (b_sel),
    .y_o    (y_wb)
  );

  // FSM state register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // FSM next state: MAC over inputs, WB per neuron, DONE once per vector.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_MAC;
      ST_MAC:  if (i_q == I_LAST) state_d = ST_WB;
      ST_WB:   state_d = (o_q == O_LAST) ? ST_DONE : ST_MAC;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: ap_ready is combinational on the accepting cycle.
  always_comb begin
    bus.ap_idle  = (state_q == ST_IDLE);
    bus.ap_ready = accept;
    bus.ap_done  = (state_q == ST_DONE);
    bus.out_vld  = (state_q == ST_DONE);
  end

  // Coefficient file: writes only land while idle; out-of-range addresses match nothing.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int k = 0; k < N_C; k++) coef_q[k] <= '0;
    end else if ((state_q == ST_IDLE) && bus.cfg_we) begin
      for (int k = 0; k < N_C; k++)
        if (int'(bus.cfg_addr) == k) coef_q[k] <= bus.cfg_wdata;
    end
  end

  // Datapath: latch the vector, accumulate, write back each neuron's result.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      x_q   <= '0;
      acc_q <= '0;
      i_q   <= '0;
      o_q   <= '0;
      out_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            x_q   <= bus.in_data;
            acc_q <= '0;
            i_q   <= '0;
            o_q   <= '0;
          end
        end
        ST_MAC: begin
          acc_q <= acc_q + prod_ext;
          if (i_q != I_LAST) i_q <= i_q + IW'(1);
        end
        ST_WB: begin
          for (int k = 0; k < N_OUT; k++)
            if (int'(o_q) == k) out_q[k*DATA_W +: DATA_W] <= y_wb;
          if (o_q != O_LAST) begin
            o_q   <= o_q + OW'(1);
            i_q   <= '0;
            acc_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_layer_seq.sv
// tb_dense_layer_seq: directed vectors on three configurations, scoreboard-checked by a monitor.
// Latency: expected done latency per configuration is checked from the ap_ready sample.
// Backpressure: the monitor also checks that ap_idle stays low for the whole run.
module tb_dense_layer_seq;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 0: defaults, 1: defaults with RELU, 2: N_IN=4 N_OUT=3
  dense_layer_seq_if #(.N_IN(2), .N_OUT(1), .DATA_W(16)) if_a ();
  dense_layer_seq_if #(.N_IN(2), .N_OUT(1), .DATA_W(16)) if_r ();
  dense_layer_seq_if #(.N_IN(4), .N_OUT(3), .DATA_W(16)) if_b ();

  dense_layer_seq #(.N_IN(2), .N_OUT(1), .DATA_W(16), .FRAC_SHIFT(10), .ACC_W(40),
                    .SATURATE(1), .RELU(0))
    dut_a (.ap_clk(clk), .ap_rst_n(rst_n), .bus(if_a.slave));
  dense_layer_seq #(.N_IN(2), .N_OUT(1), .DATA_W(16), .FRAC_SHIFT(10), .ACC_W(40),
                    .SATURATE(1), .RELU(1))
    dut_r (.ap_clk(clk), .ap_rst_n(rst_n), .bus(if_r.slave));
  dense_layer_seq #(.N_IN(4), .N_OUT(3), .DATA_W(16), .FRAC_SHIFT(10), .ACC_W(40),
                    .SATURATE(1), .RELU(0))
    dut_b (.ap_clk(clk), .ap_rst_n(rst_n), .bus(if_b.slave));

  logic        start_d [3];
  logic        vld_d   [3];
  logic        we_d    [3];
  logic [3:0]  addr_d  [3];
  logic [15:0] wd_d    [3];
  logic [63:0] x_d     [3];
  logic        rdy [3], done [3], idle [3], ovld [3];
  logic [47:0] od  [3];

  assign if_a.ap_start = start_d[0];  assign if_r.ap_start = start_d[1];  assign if_b.ap_start = start_d[2];
  assign if_a.in_vld   = vld_d[0];    assign if_r.in_vld   = vld_d[1];    assign if_b.in_vld   = vld_d[2];
  assign if_a.cfg_we   = we_d[0];     assign if_r.cfg_we   = we_d[1];     assign if_b.cfg_we   = we_d[2];
  assign if_a.cfg_addr = addr_d[0][1:0];
  assign if_r.cfg_addr = addr_d[1][1:0];
  assign if_b.cfg_addr = addr_d[2];
  assign if_a.cfg_wdata = wd_d[0];    assign if_r.cfg_wdata = wd_d[1];    assign if_b.cfg_wdata = wd_d[2];
  assign if_a.in_data  = x_d[0][31:0];
  assign if_r.in_data  = x_d[1][31:0];
  assign if_b.in_data  = x_d[2];

  assign rdy[0]  = if_a.ap_ready; assign rdy[1]  = if_r.ap_ready; assign rdy[2]  = if_b.ap_ready;
  assign done[0] = if_a.ap_done;  assign done[1] = if_r.ap_done;  assign done[2] = if_b.ap_done;
  assign idle[0] = if_a.ap_idle;  assign idle[1] = if_r.ap_idle;  assign idle[2] = if_b.ap_idle;
  assign ovld[0] = if_a.out_vld;  assign ovld[1] = if_r.out_vld;  assign ovld[2] = if_b.out_vld;
  assign od[0]   = {32'b0, if_a.out_data};
  assign od[1]   = {32'b0, if_r.out_data};
  assign od[2]   = if_b.out_data;

  typedef struct { int id; logic [47:0] y; } exp_t;
  exp_t expq [$];

  int lat     [3] = '{4, 4, 16};
  bit busy    [3];
  int rdy_cyc [3];
  int rdy_cnt [3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pk2(input int a, input int b);
    return {32'b0, b[15:0], a[15:0]};
  endfunction

  task automatic cfg_write(input int k, input int a, input int d);
    we_d[k]   = 1'b1;
    addr_d[k] = 4'(a);
    wd_d[k]   = 16'(d);
    tick();
    we_d[k]   = 1'b0;
  endtask

  // Returns just after the accepting edge.
  task automatic wait_ready(input int k);
    int n;
    n = 0;
    @(negedge clk);
    while (!rdy[k] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("ready_seen_%0d", k), 64'(rdy[k]), 64'd1);
    tick();
  endtask

  task automatic wait_done(input int k);
    int n;
    n = 0;
    while (busy[k] && n < 100) begin
      tick();
      n++;
    end
    check($sformatf("done_in_time_%0d", k), 64'(busy[k]), 64'd0);
  endtask

  task automatic run(input int k, input logic [63:0] x, input logic [47:0] y);
    x_d[k]     = x;
    start_d[k] = 1'b1;
    vld_d[k]   = 1'b1;
    wait_ready(k);
    expq.push_back('{k, y});
    start_d[k] = 1'b0;
    vld_d[k]   = 1'b0;
    wait_done(k);
  endtask

  // Monitor: latency, idle and vld/done consistency, and scoreboard pop on every done.
  initial begin
    exp_t e;
    bit   hit;
    for (int k = 0; k < 3; k++) begin busy[k] = 1'b0; rdy_cyc[k] = 0; rdy_cnt[k] = 0; end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (!rst_n) begin
          busy[k] = 1'b0;
        end else begin
          if (busy[k]) check($sformatf("idle_low_%0d", k), 64'(idle[k]), 64'd0);
          if (done[k] || ovld[k]) check($sformatf("vld_eq_done_%0d", k), 64'(ovld[k]), 64'(done[k]));
          if (done[k]) begin
            check($sformatf("done_had_run_%0d", k), 64'(busy[k]), 64'd1);
            if (busy[k]) check($sformatf("latency_%0d", k), 64'(cyc - rdy_cyc[k]), 64'(lat[k]));
            busy[k] = 1'b0;
            hit = (expq.size() > 0) && (expq[0].id == k);
            if (hit) begin
              e = expq.pop_front();
              check($sformatf("y_%0d", k), {16'b0, od[k]}, {16'b0, e.y});
            end else begin
              check($sformatf("done_expected_%0d", k), 64'(hit), 64'd1);
            end
          end
          if (rdy[k]) begin
            busy[k]    = 1'b1;
            rdy_cyc[k] = cyc;
            rdy_cnt[k] = rdy_cnt[k] + 1;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c1, c2, r0;
    for (int k = 0; k < 3; k++) begin
      start_d[k] = 1'b0; vld_d[k] = 1'b0; we_d[k] = 1'b0;
      addr_d[k]  = '0;   wd_d[k]  = '0;   x_d[k]  = '0;
    end
    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_out_%0d", k),   {16'b0, od[k]},  64'd0);
      check($sformatf("rst_idle_%0d", k),  64'(idle[k]),    64'd1);
      check($sformatf("rst_done_%0d", k),  64'(done[k]),    64'd0);
      check($sformatf("rst_ready_%0d", k), 64'(rdy[k]),     64'd0);
    end
    rst_n = 1'b1;
    tick();

    // Defaults, back-to-back vectors with ap_start held: 173 then 1053, one vector per 5 cycles.
    cfg_write(0, 0, -288);
    cfg_write(0, 1, 304);
    cfg_write(0, 2, 157);
    x_d[0] = pk2(1024, 1024); start_d[0] = 1'b1; vld_d[0] = 1'b1;
    wait_ready(0);
    c1 = rdy_cyc[0];
    expq.push_back('{0, 48'd173});
    x_d[0] = pk2(-1024, 2048);
    wait_ready(0);
    c2 = rdy_cyc[0];
    expq.push_back('{0, 48'd1053});
    start_d[0] = 1'b0; vld_d[0] = 1'b0;
    check("throughput", 64'(c2 - c1), 64'd5);
    wait_done(0);

    // ReLU build: positives pass, -1 becomes 0.
    cfg_write(1, 0, -288);
    cfg_write(1, 1, 304);
    cfg_write(1, 2, 157);
    run(1, pk2(1024, 1024), 48'd173);
    cfg_write(1, 0, -1);
    cfg_write(1, 1, 0);
    cfg_write(1, 2, 0);
    run(1, pk2(1, 0), 48'd0);

    // 4x3 layer, unity weights, biases {0, 1, -1}, x = {1,2,3,4}.
    for (int a = 0; a < 12; a++) cfg_write(2, a, 1024);
    cfg_write(2, 12, 0);
    cfg_write(2, 13, 1);
    cfg_write(2, 14, -1);
    run(2, {16'd4, 16'd3, 16'd2, 16'd1}, {16'd9, 16'd11, 16'd10});

    // Saturation at both ends.
    cfg_write(0, 0, 32767);
    cfg_write(0, 1, 32767);
    cfg_write(0, 2, 0);
    run(0, pk2(32767, 32767), 48'h7FFF);
    run(0, pk2(-32768, -32768), 48'h8000);

    // Write coincident with acceptance is used by that run: w0 = -1 gives 0xFFFF, not 31.
    cfg_write(0, 1, 0);
    we_d[0] = 1'b1; addr_d[0] = 4'd0; wd_d[0] = 16'hFFFF;
    x_d[0] = pk2(1, 0); start_d[0] = 1'b1; vld_d[0] = 1'b1;
    wait_ready(0);
    we_d[0] = 1'b0; start_d[0] = 1'b0; vld_d[0] = 1'b0;
    expq.push_back('{0, 48'hFFFF});
    wait_done(0);

    // ap_start held, in_vld toggling; a write during MAC is dropped; in_data changes ignored.
    cfg_write(0, 0, 1024);
    r0 = rdy_cnt[0];
    x_d[0] = pk2(3000, 0); start_d[0] = 1'b1; vld_d[0] = 1'b0;
    repeat (3) tick();
    check("no_accept_without_vld", 64'(rdy_cnt[0] - r0), 64'd0);
    vld_d[0] = 1'b1;
    wait_ready(0);
    expq.push_back('{0, 48'd3000});
    vld_d[0] = 1'b0;
    x_d[0] = pk2(555, 555);
    we_d[0] = 1'b1; addr_d[0] = 4'd0; wd_d[0] = 16'd0;
    tick();
    we_d[0] = 1'b0;
    wait_done(0);
    repeat (3) tick();
    check("accepts_after_first", 64'(rdy_cnt[0] - r0), 64'd1);
    x_d[0] = pk2(7, 0); vld_d[0] = 1'b1;
    wait_ready(0);
    expq.push_back('{0, 48'd7});
    start_d[0] = 1'b0; vld_d[0] = 1'b0;
    wait_done(0);
    check("accepts_total", 64'(rdy_cnt[0] - r0), 64'd2);

    // Reset during MAC: no done for that run, state and coefficients cleared.
    x_d[0] = pk2(1024, 1024); start_d[0] = 1'b1; vld_d[0] = 1'b1;
    wait_ready(0);
    start_d[0] = 1'b0; vld_d[0] = 1'b0;
    rst_n = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("midrst_out_%0d", k),  {16'b0, od[k]}, 64'd0);
      check($sformatf("midrst_idle_%0d", k), 64'(idle[k]),   64'd1);
    end
    rst_n = 1'b1;
    repeat (8) tick();
    check("midrst_no_done", 64'(done[0]), 64'd0);
    run(0, pk2(1024, 1024), 48'd0);

    repeat (5) tick();
    check("scoreboard_empty", 64'(expq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dense_layer_seq.md
Name: dense_layer_seq

Overview:
- Parametrised, time-multiplexed fully-connected layer for the fixed-point inference datapath. Successor to the fixed-weight, two-input, single-output dense stage.
- Computes N_OUT outputs, each the sum over N_IN inputs of x[i]*w[o][i], requantised, plus bias.
- Weights and biases are runtime-loadable. Saturation and ReLU are optional.
- Uses the ap_start/ap_done/ap_idle/ap_ready block-level handshake, so it chains directly with the other generated layer blocks.

Parameters:
- N_IN, 2, number of input activations per vector
- N_OUT, 1, number of output neurons
- DATA_W, 16, signed width of activations, weights, biases and outputs
- FRAC_SHIFT, 10, arithmetic right shift applied to the accumulator before the bias add
- ACC_W, 40, signed accumulator width; must be >= 2*DATA_W + clog2(N_IN)
- SATURATE, 1, 1 = clamp the result to the DATA_W signed range; 0 = keep the low DATA_W bits (wrap)
- RELU, 0, 1 = negative results forced to 0

Ports:
- ap_clk  in  1  clock
- ap_rst_n  in  1  asynchronous, active-low reset
- ap_start  in  1  request to process one vector
- ap_done  out  1  one-cycle pulse: results valid
- ap_idle  out  1  high while in IDLE
- ap_ready  out  1  one-cycle pulse: input vector accepted
- in_vld  in  1  in_data is valid
- in_data  in  N_IN*DATA_W  packed signed inputs; x[i] = in_data[i*DATA_W +: DATA_W]
- cfg_we  in  1  coefficient write strobe
- cfg_addr  in  clog2(N_IN*N_OUT+N_OUT)  coefficient address:
  - addresses 0 .. N_IN*N_OUT-1 hold weight w[o][i] at address o*N_IN+i
  - the following N_OUT addresses hold bias b[o]
- cfg_wdata  in  DATA_W  signed coefficient value
- out_data  out  N_OUT*DATA_W  packed signed results; y[o] = out_data[o*DATA_W +: DATA_W]
- out_vld  out  1  identical to ap_done

Behaviour:
- Reset (ap_rst_n low, asynchronous):
  - state = IDLE
  - all weights, biases and out_data = 0
  - ap_done, ap_ready and out_vld = 0
  - ap_idle = 1 once in IDLE
  - reset mid-run abandons the computation; no ap_done is produced.
- FSM states: IDLE, MAC, WB, DONE.
- IDLE:
  - Acceptance occurs when ap_start && in_vld: ap_ready = 1 that cycle (combinational), in_data is latched, o = 0, i = 0, acc = 0, next state MAC.
  - ap_start without in_vld: remain in IDLE, no ap_ready.
- MAC:
  - Each cycle: acc += sext(x[i]*w[o][i]), with a full-precision 2*DATA_W product.
  - If i == N_IN-1, next state is WB; otherwise i++.
- WB:
  - r = (acc >>> FRAC_SHIFT) + sext(b[o]). Floor semantics: -1 >>> 10 = -1.
  - Apply SATURATE (clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1]) or wrap; then apply RELU.
  - Write y[o] into the out_data register.
  - If o == N_OUT-1, next state is DONE; otherwise o++, i = 0, acc = 0, next state MAC.
- DONE: ap_done = out_vld = 1 for exactly one cycle; next state IDLE.
- Latency: ap_done is high in cycle N_OUT*(N_IN+1)+1 after the accepting edge (defaults: cycle 4).
- Throughput: one vector per N_OUT*(N_IN+1)+2 cycles when ap_start is held high.
- Output hold: out_data holds its last value until overwritten during the next run. y[o] is updated at its WB edge, so out_data is only guaranteed coherent while out_vld is high.
- Coefficient writes:
  - Taken only in IDLE. Writes in any other state are dropped silently.
  - Out-of-range cfg_addr is ignored.
  - cfg_we coincident with acceptance: the write takes effect and the run uses the new value.
- Inputs are sampled only at acceptance. Changes to in_data during a run have no effect.

Decomposition:
- Shared package dense_pkg holds:
  - the FSM state enum
  - function clog2
  - the address-map helper (weight index o*N_IN+i, bias base N_IN*N_OUT)
  - a saturate-to-DATA_W function reused by other layers
- One sub-module, fx_requant (combinational). It takes acc, bias, FRAC_SHIFT, SATURATE and RELU and produces y.
- The MAC, FSM and coefficient register file stay in dense_layer_seq.

Test Plan:
- Defaults; load w0 = -288, w1 = 304, b0 = 157; send x0 = 1024, x1 = 1024 -> ap_ready in the accept cycle, ap_done in cycle 4 after, y0 = 173.
- Same coefficients; x0 = -1024, x1 = 2048 -> acc = 917504, y0 = 1053.
- Boundary arithmetic, with w0 = 32767, w1 = 32767, b0 = 0:
  - x0 = x1 = 32767, SATURATE = 1 -> y0 = 32767 (0x7FFF).
  - w0 = -1, w1 = 0, x0 = 1, x1 = 0 -> y0 = 0xFFFF with RELU = 0; y0 = 0 with RELU = 1.
- N_IN = 4, N_OUT = 3, all weights 1024 (i.e. 1.0), b = {0, 1, -1}, x = {1, 2, 3, 4} -> y = {10, 11, 9}; ap_done at cycle 16; ap_idle low throughout the run.
- ap_start held high with in_vld toggling; a cfg write issued during MAC -> accepts occur only with in_vld in IDLE; the mid-run write is dropped (read back through the next run's result).
- Assert ap_rst_n low during MAC -> ap_done is never pulsed for that run; out_data = 0 and ap_idle = 1 after reset; coefficients = 0, so the next run yields y0 = 0.
